buyruk_onbellek_ckyollu: RTL
============================

Name: buyruk_onbellek_ckyollu

Overview:
Parametrised set-associative instruction cache between the fetch (getir) stage and the main-memory controller (anabellek denetleyici); successor to the direct-mapped 128-line fetch cache.
Adds configurable ways, sets and line width, tree pseudo-LRU replacement, request-address capture, back-to-back hit pipelining, fetch cancellation and full invalidation for fence.i.
Storage is synchronous single-port RAM per way (1-cycle read); valid and PLRU bits are flops.

Parameters:
YOL_SAYISI, 2, ways per set; legal values 1, 2, 4.
SATIR_SAYISI, 128, sets; power of 2 (index bits IB = log2).
OBEK_BIT, 128, line width in bits; power of 2, >= 64 (offset bits OB = log2(OBEK_BIT/8)).
ADRES_BIT, 32, address width; tag width ETB = ADRES_BIT-IB-OB.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
adres_i  in  ADRES_BIT  fetch address; word-aligned, bits [1:0] ignored
istek_i  in  1  fetch request valid
durdur_i  in  1  fetch stage stall
iptal_i  in  1  cancel outstanding fetch (branch redirect)
temizle_i  in  1  invalidate whole cache
anabellek_musait_i  in  1  controller can accept a request
anabellek_hazir_i  in  1  refill line valid (one-cycle pulse)
anabellek_obek_i  in  OBEK_BIT  refill line
anabellek_adres_o  out  ADRES_BIT  line-aligned refill address
anabellek_istek_o  out  1  refill request pulse
anabellek_oku_o  out  1  constant 1
buyruk_o  out  32  instruction
buyruk_hazir_o  out  1  instruction valid, one-cycle pulse
temizle_bitti_o  out  1  invalidation done pulse

Behaviour:
- Reset (rst_i low, asynchronous): state BOSTA; all valid and PLRU bits 0; every output 0 except anabellek_oku_o = 1; captured address 0. Reset mid-refill abandons it; a late anabellek_hazir_i in BOSTA is ignored.
- States: BOSTA, KARSILASTIR, ISKA_BEKLE, ANABELLEK.
- BOSTA: istek_i & !durdur_i & !temizle_i -> capture adres_i, read all ways at index, go KARSILASTIR. temizle_i has priority: clear all valid bits that cycle, temizle_bitti_o = 1 next cycle, stay BOSTA.
- KARSILASTIR: hit = valid & tag match in exactly one way.
  - Hit: buyruk_o = word at captured offset[OB-1:2], buyruk_hazir_o = 1, PLRU updated toward the hit way. If istek_i & !durdur_i the same cycle, accept the next address and stay KARSILASTIR (1-cycle hit latency, 1 fetch/cycle); otherwise go BOSTA.
  - Miss: go ISKA_BEKLE.
  - durdur_i high: hold state and RAM output, no pulse. iptal_i: drop to BOSTA, no pulse.
- ISKA_BEKLE: when anabellek_musait_i, issue one-cycle anabellek_istek_o with {tag, index, OB zeros}, go ANABELLEK. iptal_i here: go BOSTA with no request issued.
- ANABELLEK: anabellek_adres_o holds the line address. On anabellek_hazir_i:
  - write line and tag into the victim way and set valid; victim is the lowest-index invalid way, else PLRU victim.
  - update PLRU toward the victim; go BOSTA.
  - buyruk_hazir_o = 1 with the word from anabellek_obek_i, unless iptal_i was seen during ANABELLEK (sticky flag); then the fill completes silently.
- temizle_i outside BOSTA is latched and performed on the next entry to BOSTA.
- PLRU: 1 way: none. 2 ways: 1 bit per set. 4 ways: 3-bit tree per set.
- Word select never exceeds the line (no cross-line fetch).

Optional Feature:
BBELLEK_SAYAC_EN: adds outputs isabet_sayisi_o [31:0] and iska_sayisi_o [31:0].
- Counters are wrapping, incremented on each hit and each miss decision in KARSILASTIR, reset to 0, and cleared by temizle_i.
- Without the macro, the ports and logic are absent.

Decomposition:
- Shared package/header bbellek_tanim.vh: state encodings, IB/OB/ETB derivation macros, PLRU victim and update functions.
- Sub-module onbellek_yol_bellek: one way of tag+data synchronous RAM (en, wen, index, ETB+OBEK_BIT data), instantiated YOL_SAYISI times.

Test Plan:
- Reset, then fetch 0x0000_1000 -> miss, anabellek_istek_o with address 0x1000; refill pattern -> buyruk_hazir_o with word 0; refetch 0x1004 -> hit one cycle after acceptance, word 1.
- Back-to-back hits 0x1000, 0x1004, 0x1008, 0x100C with istek_i held -> four consecutive buyruk_hazir_o pulses.
- YOL_SAYISI=2: fill 0x1000 and 0x1800 (same set), touch 0x1000, fetch 0x2000 -> 0x1800 evicted; 0x1000 still hits.
- iptal_i during ANABELLEK for 0x3000 -> no buyruk_hazir_o; a later 0x3000 fetch hits.
- temizle_i after three fills -> temizle_bitti_o the next cycle; all three addresses then miss.
- rst_i low mid-refill -> outputs 0 immediately; a subsequent anabellek_hazir_i pulse is ignored; the first fetch after reset misses.

Source files
------------

// File: rtl/buyruk_onbellek_ckyollu_pkg.sv
`default_nettype none
// ============================================================================
// buyruk_onbellek_ckyollu_pkg: FSM states and tree pseudo-LRU helpers. Rev 1.0
// ============================================================================
package buyruk_onbellek_ckyollu_pkg;

    typedef enum logic [1:0] {
        BOSTA       = 2'd0,
        KARSILASTIR = 2'd1,
        ISKA_BEKLE  = 2'd2,
        ANABELLEK   = 2'd3
    } durum_t;

    localparam int KELIME_BIT = 32;

    // Tree bits point at the victim side: bit0 picks pair {0,1}/{2,3}, bit1/bit2 pick within a pair.
    function automatic logic [1:0] plru_kurban(input logic [2:0] agac, input int yol_sayisi);
        if (yol_sayisi == 4)
            return agac[0] ? {1'b1, agac[2]} : {1'b0, agac[1]};
        else if (yol_sayisi == 2)
            return {1'b0, agac[0]};
        else
            return 2'd0;
    endfunction

    function automatic logic [2:0] plru_guncelle(input logic [2:0] agac, input logic [1:0] yol,
                                                 input int yol_sayisi);
        logic [2:0] yeni;
        yeni = agac;
        if (yol_sayisi == 4) begin
            if (!yol[1]) begin
                yeni[0] = 1'b1;
                yeni[1] = ~yol[0];
            end else begin
                yeni[0] = 1'b0;
                yeni[2] = ~yol[0];
            end
        end else if (yol_sayisi == 2) begin
            yeni[0] = ~yol[0];
        end
        return yeni;
    endfunction

endpackage
`default_nettype wire

// File: rtl/buyruk_onbellek_ckyollu_yol_bellek.sv
`default_nettype none
// ============================================================================
// onbellek_yol_bellek: one cache way, tag+line synchronous single-port RAM. Rev 1.0
// ============================================================================
module onbellek_yol_bellek #(
    parameter int SATIR_SAYISI = 128,
    parameter int GENISLIK     = 149
) (
    input  logic                            clk,
    input  logic                            en,
    input  logic                            wen,
    input  logic [$clog2(SATIR_SAYISI)-1:0] indeks,
    input  logic [GENISLIK-1:0]             yaz_veri,
    output logic [GENISLIK-1:0]             oku_veri
);

    logic [GENISLIK-1:0] hafiza [SATIR_SAYISI];

    // Read data is held while en is low, so a stalled compare keeps its line.
    always_ff @(posedge clk) begin
        if (en) begin
            if (wen)
                hafiza[indeks] <= yaz_veri;
            else
                oku_veri <= hafiza[indeks];
        end
    end

endmodule
`default_nettype wire

// File: rtl/buyruk_onbellek_ckyollu.sv
`default_nettype none
// ============================================================================
// buyruk_onbellek_ckyollu: set-associative fetch cache with tree PLRU, cancel and flush.
// Optional hit/miss counters with `define BBELLEK_SAYAC_EN. Rev 1.0
// ============================================================================
module buyruk_onbellek_ckyollu
    import buyruk_onbellek_ckyollu_pkg::*;
#(
    parameter int YOL_SAYISI   = 2,
    parameter int SATIR_SAYISI = 128,
    parameter int OBEK_BIT     = 128,
    parameter int ADRES_BIT    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADRES_BIT-1:0] adres_i,
    input  logic                 istek_i,
    input  logic                 durdur_i,
    input  logic                 iptal_i,
    input  logic                 temizle_i,
    input  logic                 anabellek_musait_i,
    input  logic                 anabellek_hazir_i,
    input  logic [OBEK_BIT-1:0]  anabellek_obek_i,
    output logic [ADRES_BIT-1:0] anabellek_adres_o,
    output logic                 anabellek_istek_o,
    output logic                 anabellek_oku_o,
    output logic [31:0]          buyruk_o,
    output logic                 buyruk_hazir_o,
    output logic                 temizle_bitti_o
`ifdef BBELLEK_SAYAC_EN
    ,
    output logic [31:0]          isabet_sayisi_o,
    output logic [31:0]          iska_sayisi_o
`endif
);

    localparam int IB  = $clog2(SATIR_SAYISI);
    localparam int OB  = $clog2(OBEK_BIT / 8);
    localparam int ETB = ADRES_BIT - IB - OB;
    localparam int YB  = (YOL_SAYISI > 1) ? $clog2(YOL_SAYISI) : 1;
    localparam int VB  = ETB + OBEK_BIT;
    localparam int WB  = OB - 2;

    durum_t durum, sonraki_durum;

    logic [ADRES_BIT-3:0]                   yakalanan;
    logic [SATIR_SAYISI-1:0][YOL_SAYISI-1:0] gecerli;
    logic [SATIR_SAYISI-1:0][2:0]            plru;
    logic                                   temizle_bekle, iptal_bayrak;

    logic [VB-1:0]         ram_cikis [YOL_SAYISI];
    logic [YOL_SAYISI-1:0] eslesme;
    logic [IB-1:0]         yak_indeks, okuma_indeks;
    logic [ETB-1:0]        yak_etiket;
    logic [WB-1:0]         yak_kelime;
    logic [YB-1:0]         isabet_yol, kurban, plru_yol;
    logic [2:0]            eslesme_sayisi;
    logic                  isabet, kabul, yaz, temizle_yap, plru_yaz, isabet_karar, iska_karar;
    logic [OBEK_BIT-1:0]   isabet_obek;
    logic                  adres_unused;

    // Byte-in-word bits are never needed; only bits [ADRES_BIT-1:2] are captured.
    assign adres_unused = ^adres_i[1:0];
    assign yak_indeks   = yakalanan[OB+IB-3:OB-2];
    assign yak_etiket   = yakalanan[ADRES_BIT-3:OB+IB-2];
    assign yak_kelime   = yakalanan[WB-1:0];
    assign okuma_indeks = adres_i[OB+IB-1:OB];

    for (genvar y = 0; y < YOL_SAYISI; y++) begin : g_yol
        onbellek_yol_bellek #(
            .SATIR_SAYISI(SATIR_SAYISI),
            .GENISLIK    (VB)
        ) u_bellek (
            .clk     (clk_i),
            .en      (kabul || (yaz && kurban == YB'(y))),
            .wen     (yaz),
            .indeks  (yaz ? yak_indeks : okuma_indeks),
            .yaz_veri({yak_etiket, anabellek_obek_i}),
            .oku_veri(ram_cikis[y])
        );
        assign eslesme[y] = gecerli[yak_indeks][y] && (ram_cikis[y][VB-1:OBEK_BIT] == yak_etiket);
    end

    always_comb begin
        eslesme_sayisi = 3'd0;
        isabet_yol     = '0;
        kurban         = YB'(plru_kurban(plru[yak_indeks], YOL_SAYISI));
        for (int y = 0; y < YOL_SAYISI; y++) begin
            if (eslesme[y]) begin
                eslesme_sayisi = eslesme_sayisi + 3'd1;
                isabet_yol     = YB'(y);
            end
        end
        // Descending scan so the lowest-index empty way is the one left standing.
        for (int y = YOL_SAYISI - 1; y >= 0; y--) begin
            if (!gecerli[yak_indeks][y])
                kurban = YB'(y);
        end
    end

    assign isabet      = (eslesme_sayisi == 3'd1);
    assign isabet_obek = ram_cikis[isabet_yol][OBEK_BIT-1:0];

    always_comb begin
        sonraki_durum     = durum;
        buyruk_o          = '0;
        buyruk_hazir_o    = 1'b0;
        anabellek_istek_o = 1'b0;
        kabul             = 1'b0;
        yaz               = 1'b0;
        temizle_yap       = 1'b0;
        plru_yaz          = 1'b0;
        plru_yol          = isabet_yol;
        isabet_karar      = 1'b0;
        iska_karar        = 1'b0;
        case (durum)
            BOSTA: begin
                if (temizle_i || temizle_bekle) begin
                    temizle_yap = 1'b1;
                end else if (istek_i && !durdur_i) begin
                    kabul         = 1'b1;
                    sonraki_durum = KARSILASTIR;
                end
            end
            KARSILASTIR: begin
                if (iptal_i) begin
                    sonraki_durum = BOSTA;
                end else if (!durdur_i) begin
                    if (isabet) begin
                        buyruk_o       = isabet_obek[{yak_kelime, 5'd0} +: KELIME_BIT];
                        buyruk_hazir_o = 1'b1;
                        isabet_karar   = 1'b1;
                        plru_yaz       = 1'b1;
                        // A pending flush must reach BOSTA before any further lookups.
                        if (istek_i && !temizle_i && !temizle_bekle)
                            kabul = 1'b1;
                        else
                            sonraki_durum = BOSTA;
                    end else begin
                        iska_karar    = 1'b1;
                        sonraki_durum = ISKA_BEKLE;
                    end
                end
            end
            ISKA_BEKLE: begin
                if (iptal_i) begin
                    sonraki_durum = BOSTA;
                end else if (anabellek_musait_i) begin
                    anabellek_istek_o = 1'b1;
                    sonraki_durum     = ANABELLEK;
                end
            end
            ANABELLEK: begin
                if (anabellek_hazir_i) begin
                    yaz           = 1'b1;
                    plru_yaz      = 1'b1;
                    plru_yol      = kurban;
                    sonraki_durum = BOSTA;
                    if (!iptal_i && !iptal_bayrak) begin
                        buyruk_o       = anabellek_obek_i[{yak_kelime, 5'd0} +: KELIME_BIT];
                        buyruk_hazir_o = 1'b1;
                    end
                end
            end
            default: sonraki_durum = BOSTA;
        endcase
    end

    assign anabellek_oku_o   = 1'b1;
    assign anabellek_adres_o = (durum == ISKA_BEKLE || durum == ANABELLEK)
                             ? {yakalanan[ADRES_BIT-3:OB-2], {OB{1'b0}}} : '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum           <= BOSTA;
            yakalanan       <= '0;
            gecerli         <= '0;
            plru            <= '0;
            temizle_bekle   <= 1'b0;
            temizle_bitti_o <= 1'b0;
            iptal_bayrak    <= 1'b0;
        end else begin
            durum           <= sonraki_durum;
            temizle_bitti_o <= temizle_yap;
            if (kabul)
                yakalanan <= adres_i[ADRES_BIT-1:2];
            if (temizle_yap)
                gecerli <= '0;
            else if (yaz)
                gecerli[yak_indeks][kurban] <= 1'b1;
            if (plru_yaz)
                plru[yak_indeks] <= plru_guncelle(plru[yak_indeks], 2'(plru_yol), YOL_SAYISI);
            if (temizle_yap)
                temizle_bekle <= 1'b0;
            else if (temizle_i && durum != BOSTA)
                temizle_bekle <= 1'b1;
            iptal_bayrak <= (durum == ANABELLEK && sonraki_durum == ANABELLEK)
                          ? (iptal_bayrak || iptal_i) : 1'b0;
        end
    end

`ifdef BBELLEK_SAYAC_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            isabet_sayisi_o <= '0;
            iska_sayisi_o   <= '0;
        end else if (temizle_i) begin
            isabet_sayisi_o <= '0;
            iska_sayisi_o   <= '0;
        end else begin
            if (isabet_karar)
                isabet_sayisi_o <= isabet_sayisi_o + 32'd1;
            if (iska_karar)
                iska_sayisi_o <= iska_sayisi_o + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire
